// File: rtl/riscv_run_monitor.sv
// riscv_run_monitor: run gate, cycle counter and register-file dump engine
// Streams architectural registers over valid/ready once the CPU stops.
module riscv_run_monitor #(
  parameter  int XLEN    = 32,
  parameter  int NREGS   = 32,
  parameter  int CNT_W   = 32,
  parameter  int TIMEOUT = 100,
  parameter  int SKIP_X0 = 0,
  localparam int IDX_W   = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             cpu_done,
  output logic             cpu_run,
  output logic [CNT_W-1:0] clock_count,
  output logic             timed_out,
  output logic             busy,
  output logic             finished,
  output logic [IDX_W-1:0] rf_addr,
  output logic             rf_rd_en,
  input  logic [XLEN-1:0]  rf_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_idx,
  output logic [XLEN-1:0]  dump_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_RD,
    S_CAP,
    S_OUT,
    S_FIN
  } state_t;

  // Dedicated timeout timer so a narrow saturating clock_count
  // cannot hide a timeout that lies beyond its range.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_FIRST =
    (SKIP_X0 != 0) ? IDX_W'(1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREGS - 1);

  state_t           r_state;
  logic [TW-1:0]    r_tmr;
  logic [IDX_W-1:0] r_idx;
  logic             r_cpu_run;
  logic [CNT_W-1:0] r_count;
  logic             r_timed_out;
  logic             r_busy;
  logic             r_finished;
  logic [IDX_W-1:0] r_rf_addr;
  logic             r_rf_rd_en;
  logic             r_dump_valid;
  logic [IDX_W-1:0] r_dump_idx;
  logic [XLEN-1:0]  r_dump_data;

  logic [CNT_W-1:0] w_count_inc;
  logic             w_to_hit;
  logic [IDX_W-1:0] w_idx_next;

  assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);
  assign w_to_hit    = (TIMEOUT != 0) && (r_tmr == TO_LAST);
  assign w_idx_next  = r_idx + IDX_W'(1);

  // Run/dump sequencer; every output is a register updated here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_tmr        <= '0;
      r_idx        <= '0;
      r_cpu_run    <= 1'b0;
      r_count      <= '0;
      r_timed_out  <= 1'b0;
      r_busy       <= 1'b0;
      r_finished   <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_rd_en   <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_idx   <= '0;
      r_dump_data  <= '0;
    end else begin
      // Read strobe lasts one cycle unless a transition re-arms it.
      r_rf_rd_en <= 1'b0;
      if (abort && r_state != S_IDLE) begin
        r_state      <= S_IDLE;
        r_cpu_run    <= 1'b0;
        r_dump_valid <= 1'b0;
        r_finished   <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE, S_FIN: begin
            if (start) begin
              r_state     <= S_RUN;
              r_tmr       <= '0;
              r_count     <= '0;
              r_timed_out <= 1'b0;
              r_finished  <= 1'b0;
              r_cpu_run   <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
          S_RUN: begin
            r_count <= w_count_inc;
            r_tmr   <= r_tmr + TW'(1);
            if (cpu_done || w_to_hit) begin
              // A done in the timeout cycle is a clean finish.
              r_timed_out <= ~cpu_done;
              r_cpu_run   <= 1'b0;
              r_idx       <= IDX_FIRST;
              r_rf_addr   <= IDX_FIRST;
              r_rf_rd_en  <= 1'b1;
              r_state     <= S_RD;
            end
          end
          S_RD: begin
            r_state <= S_CAP;
          end
          S_CAP: begin
            r_dump_data  <= rf_data;
            r_dump_idx   <= r_idx;
            r_dump_valid <= 1'b1;
            r_state      <= S_OUT;
          end
          S_OUT: begin
            if (dump_ready) begin
              r_dump_valid <= 1'b0;
              if (r_idx == IDX_LAST) begin
                r_finished <= 1'b1;
                r_busy     <= 1'b0;
                r_state    <= S_FIN;
              end else begin
                r_idx      <= w_idx_next;
                r_rf_addr  <= w_idx_next;
                r_rf_rd_en <= 1'b1;
                r_state    <= S_RD;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cpu_run     = r_cpu_run;
  assign clock_count = r_count;
  assign timed_out   = r_timed_out;
  assign busy        = r_busy;
  assign finished    = r_finished;
  assign rf_addr     = r_rf_addr;
  assign rf_rd_en    = r_rf_rd_en;
  assign dump_valid  = r_dump_valid;
  assign dump_idx    = r_dump_idx;
  assign dump_data   = r_dump_data;

endmodule

// File: tb/tb_riscv_run_monitor.sv
// tb_riscv_run_monitor: directed bench for the run monitor
// Default instance plus a narrow-counter, x0-skipping instance.
module tb_riscv_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic cpu_done = 1'b0;
  logic dump_ready = 1'b1;

  logic        cpu_run;
  logic [31:0] clock_count;
  logic        timed_out;
  logic        busy;
  logic        finished;
  logic [4:0]  rf_addr;
  logic        rf_rd_en;
  logic [31:0] rf_data = '0;
  logic        dump_valid;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  logic start2 = 1'b0;
  logic done2 = 1'b0;
  logic ready2 = 1'b1;
  logic abort2 = 1'b0;

  logic        b_cpu_run;
  logic [3:0]  b_clock_count;
  logic        b_timed_out;
  logic        b_busy;
  logic        b_finished;
  logic [3:0]  b_rf_addr;
  logic        b_rf_rd_en;
  logic [31:0] b_rf_data = '0;
  logic        b_dump_valid;
  logic [3:0]  b_dump_idx;
  logic [31:0] b_dump_data;

  int errors = 0;
  int checks = 0;

  riscv_run_monitor dut (
    .clock(clk), .reset(reset), .start(start), .abort(abort),
    .cpu_done(cpu_done), .cpu_run(cpu_run),
    .clock_count(clock_count), .timed_out(timed_out),
    .busy(busy), .finished(finished), .rf_addr(rf_addr),
    .rf_rd_en(rf_rd_en), .rf_data(rf_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data)
  );

  riscv_run_monitor #(
    .NREGS(16), .SKIP_X0(1), .CNT_W(4), .TIMEOUT(0)
  ) dut2 (
    .clock(clk), .reset(reset), .start(start2), .abort(abort2),
    .cpu_done(done2), .cpu_run(b_cpu_run),
    .clock_count(b_clock_count), .timed_out(b_timed_out),
    .busy(b_busy), .finished(b_finished), .rf_addr(b_rf_addr),
    .rf_rd_en(b_rf_rd_en), .rf_data(b_rf_data),
    .dump_valid(b_dump_valid), .dump_ready(ready2),
    .dump_idx(b_dump_idx), .dump_data(b_dump_data)
  );

  // Register file models: reg[i] = 3*i, data one cycle after strobe.
  always @(posedge clk) begin
    if (rf_rd_en) rf_data <= 32'(rf_addr) * 32'd3;
    if (b_rf_rd_en) b_rf_data <= 32'(b_rf_addr) * 32'd3;
  end

  task automatic do_run(input int done_cyc, output int run_cycles);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_cycles = 0;
    for (int c = 1; c <= 300 && cpu_run; c++) begin
      run_cycles = c;
      cpu_done = (c == done_cyc);
      @(negedge clk);
    end
    cpu_done = 1'b0;
  endtask

  task automatic collect(input int mode, input int stall_beat,
                         input string tag);
    int b = 0;
    int stall = 0;
    int cyc = 0;
    int last_cyc = 0;
    logic pv = 1'b0;
    logic pr = 1'b1;
    logic [4:0] pidx = '0;
    logic [31:0] pdata = '0;
    while (b < 32 && cyc < 3000) begin
      if (pv && !pr) begin
        checks++;
        if (dump_valid !== 1'b1 || dump_idx !== pidx ||
            dump_data !== pdata) begin
          errors++;
          $display("FAIL %s stall_hold: got v=%b i=%0d d=%0d want v=1 i=%0d d=%0d",
                   tag, dump_valid, dump_idx, dump_data, pidx, pdata);
        end
      end
      if (dump_valid) begin
        if (b == stall_beat && stall < 5) begin
          dump_ready = 1'b0;
          stall++;
        end else if (mode == 1 && b > stall_beat) begin
          dump_ready = 1'($urandom_range(0, 1));
        end else begin
          dump_ready = 1'b1;
        end
        if (dump_ready) begin
          checks++;
          if (dump_idx !== 5'(b)) begin
            errors++;
            $display("FAIL %s beat_idx: got %0d want %0d",
                     tag, dump_idx, b);
          end
          checks++;
          if (dump_data !== 32'(3 * b)) begin
            errors++;
            $display("FAIL %s beat_data: got %0d want %0d",
                     tag, dump_data, 3 * b);
          end
          if (mode == 0 && b > 0) begin
            checks++;
            if (cyc - last_cyc != 3) begin
              errors++;
              $display("FAIL %s beat_gap: got %0d want 3",
                       tag, cyc - last_cyc);
            end
          end
          last_cyc = cyc;
          b++;
        end
      end else begin
        dump_ready = 1'b1;
      end
      pv = dump_valid;
      pr = dump_ready;
      pidx = dump_idx;
      pdata = dump_data;
      @(negedge clk);
      cyc++;
    end
    dump_ready = 1'b1;
    checks++;
    if (b != 32) begin
      errors++;
      $display("FAIL %s beat_count: got %0d want 32", tag, b);
    end
    checks++;
    if (finished !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s fin_state: got fin=%b busy=%b v=%b want 1 0 0",
               tag, finished, busy, dump_valid);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_run, clock_count, timed_out, busy, finished, rf_addr,
         rf_rd_en, dump_valid, dump_idx, dump_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero want all 0");
    end
    checks++;
    if ({b_cpu_run, b_clock_count, b_busy, b_finished,
         b_dump_valid, b_dump_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs2: got nonzero want all 0");
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_done();
    int rc;
    do_run(37, rc);
    checks++;
    if (rc != 37 || clock_count !== 32'd37 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL done_run: got rc=%0d cnt=%0d to=%b want 37 37 0",
               rc, clock_count, timed_out);
    end
    checks++;
    if (busy !== 1'b1 || cpu_run !== 1'b0) begin
      errors++;
      $display("FAIL done_busy: got busy=%b run=%b want 1 0",
               busy, cpu_run);
    end
    collect(0, -1, "done");
  endtask

  task automatic test_timeout();
    int rc;
    do_run(0, rc);
    checks++;
    if (rc != 100 || clock_count !== 32'd100 || timed_out !== 1'b1) begin
      errors++;
      $display("FAIL timeout_run: got rc=%0d cnt=%0d to=%b want 100 100 1",
               rc, clock_count, timed_out);
    end
    collect(0, -1, "timeout");
    checks++;
    if (clock_count !== 32'd100 || timed_out !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: got cnt=%0d to=%b want 100 1",
               clock_count, timed_out);
    end
  endtask

  task automatic test_stall();
    int rc;
    do_run(12, rc);
    checks++;
    if (clock_count !== 32'd12 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL stall_run: got cnt=%0d to=%b want 12 0",
               clock_count, timed_out);
    end
    collect(1, 7, "stall");
  endtask

  task automatic test_coincide();
    int rc;
    do_run(100, rc);
    checks++;
    if (rc != 100 || clock_count !== 32'd100 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL coincide: got rc=%0d cnt=%0d to=%b want 100 100 0",
               rc, clock_count, timed_out);
    end
    collect(0, -1, "coincide");
  endtask

  task automatic test_abort();
    int rc;
    int n;
    do_run(10, rc);
    dump_ready = 1'b1;
    n = 0;
    while (!(dump_valid && dump_idx == 5'd10) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL abort_reach: got timeout want beat 10");
    end
    abort = 1'b1;
    dump_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    dump_ready = 1'b1;
    checks++;
    if (dump_valid !== 1'b0 || busy !== 1'b0 || finished !== 1'b0 ||
        cpu_run !== 1'b0 || rf_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got v=%b busy=%b fin=%b run=%b rd=%b want 0",
               dump_valid, busy, finished, cpu_run, rf_rd_en);
    end
    checks++;
    if (clock_count !== 32'd10 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: got cnt=%0d to=%b want 10 0",
               clock_count, timed_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b v=%b want 0 0",
               busy, dump_valid);
    end
    do_run(5, rc);
    checks++;
    if (clock_count !== 32'd5) begin
      errors++;
      $display("FAIL abort_restart: got %0d want 5", clock_count);
    end
    collect(0, -1, "restart");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cpu_run !== 1'b0 || clock_count !== '0 || busy !== 1'b0 ||
        finished !== 1'b0 || dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got run=%b cnt=%0d busy=%b want 0",
               cpu_run, clock_count, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_narrow();
    int rc;
    int b;
    int cyc;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    rc = 0;
    for (int c = 1; c <= 300 && b_cpu_run; c++) begin
      rc = c;
      done2 = (c == 20);
      @(negedge clk);
    end
    done2 = 1'b0;
    checks++;
    if (rc != 20 || b_clock_count !== 4'd15 || b_timed_out !== 1'b0) begin
      errors++;
      $display("FAIL narrow_run: got rc=%0d cnt=%0d to=%b want 20 15 0",
               rc, b_clock_count, b_timed_out);
    end
    b = 1;
    cyc = 0;
    ready2 = 1'b1;
    while (b < 16 && cyc < 500) begin
      if (b_dump_valid) begin
        checks++;
        if (b_dump_idx !== 4'(b) || b_dump_data !== 32'(3 * b)) begin
          errors++;
          $display("FAIL narrow_beat: got i=%0d d=%0d want %0d %0d",
                   b_dump_idx, b_dump_data, b, 3 * b);
        end
        b++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (b != 16 || b_finished !== 1'b1 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL narrow_end: got beats=%0d fin=%b busy=%b want 15 1 0",
               b - 1, b_finished, b_busy);
    end
  endtask

  initial begin
    test_reset();
    test_done();
    test_timeout();
    test_stall();
    test_coincide();
    test_abort();
    test_reset_mid_run();
    test_narrow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
